// File: rtl/pga_gain_ctrl.sv
// Closed-loop PGA gain controller: windowed peak detector drives a hysteretic
// gain code, which is mirrored to the external amplifier over a write-only SPI link.
module pga_gain_ctrl #(
  parameter int         WINDOW_2N = 8,
  parameter int         GAIN_W    = 4,
  parameter int         GAIN_MAX  = 15,
  parameter int         GAIN_INIT = 8,
  parameter int         HI_THRESH = 112,
  parameter int         LO_THRESH = 40,
  parameter int         CLK_DIV   = 4,
  parameter logic [7:0] CMD_BYTE  = 8'h40
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        S_TDATA,
  input  logic              S_TVALID,
  output logic [GAIN_W-1:0] gain_code,
  output logic              gain_update,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  output logic              spi_busy
);

  localparam logic [6:0]        HI_T     = 7'(HI_THRESH);
  localparam logic [6:0]        LO_T     = 7'(LO_THRESH);
  localparam logic [GAIN_W-1:0] G_MAX    = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] G_INIT   = GAIN_W'(GAIN_INIT);
  localparam int                DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CSHOLD} state_t;

  // -128 has no positive twin in 8 bits, so it folds onto 127.
  function automatic logic [6:0] sat_mag(input logic signed [7:0] x);
    logic [7:0] a;
    if (x == -8'sd128) return 7'd127;
    a = x[7] ? (~x + 8'd1) : x;
    return a[6:0];
  endfunction

  logic signed [7:0]     w_sample;
  logic [6:0]            w_mag;
  logic [6:0]            w_pk;
  logic                  w_last;
  logic                  w_need;
  logic [15:0]           w_frame_ld;

  logic [6:0]            r_peak;
  logic [WINDOW_2N-1:0]  r_cnt;
  logic [GAIN_W-1:0]     r_gain;
  logic                  r_gain_upd;

  state_t                r_state;
  logic [DIV_W-1:0]      r_div;
  logic [3:0]            r_bit;
  logic [15:0]           r_frame;
  logic [GAIN_W-1:0]     r_snap;
  logic [GAIN_W-1:0]     r_sent_code;
  logic                  r_sent_valid;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_mosi;
  logic                  r_busy;

  assign w_sample   = S_TDATA;
  assign w_mag      = sat_mag(w_sample);
  assign w_pk       = (w_mag > r_peak) ? w_mag : r_peak;
  assign w_last     = S_TVALID && (r_cnt == '1);
  assign w_need     = !r_sent_valid || (r_gain != r_sent_code);
  assign w_frame_ld = {CMD_BYTE, 8'(r_gain)};

  // Stage p0: window peak tracking and gain decision on the closing sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak     <= '0;
      r_cnt      <= '0;
      r_gain     <= G_INIT;
      r_gain_upd <= 1'b0;
    end else begin
      r_gain_upd <= 1'b0;
      if (S_TVALID) begin
        if (w_last) begin
          r_peak <= '0;
          r_cnt  <= '0;
          if (w_pk >= HI_T && r_gain != '0) begin
            r_gain     <= r_gain - 1'b1;
            r_gain_upd <= 1'b1;
          end else if (w_pk < LO_T && r_gain < G_MAX) begin
            r_gain     <= r_gain + 1'b1;
            r_gain_upd <= 1'b1;
          end
        end else begin
          r_peak <= w_pk;
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p1: SPI sequencer; sclk toggles every CLK_DIV cycles while shifting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_bit        <= '0;
      r_sent_code  <= '0;
      r_sent_valid <= 1'b0;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_mosi       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_need) begin
            r_state <= S_SHIFT;
            r_div   <= '0;
            r_bit   <= '0;
            r_cs_n  <= 1'b0;
            r_mosi  <= w_frame_ld[15];
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              r_bit <= r_bit + 1'b1;
              if (r_bit == 4'd15) begin
                r_cs_n  <= 1'b1;
                r_mosi  <= 1'b0;
                r_state <= S_CSHOLD;
              end else begin
                r_mosi <= r_frame[14];
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_CSHOLD: begin
          if (r_div == DIV_LAST) begin
            r_div        <= '0;
            r_sent_code  <= r_snap;
            r_sent_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame data path: loaded when a transfer starts, rotated on each sclk fall
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_need) begin
      r_frame <= w_frame_ld;
      r_snap  <= r_gain;
    end else if (r_state == S_SHIFT && r_div == DIV_LAST && r_sclk) begin
      r_frame <= {r_frame[14:0], r_frame[15]};
    end
  end

  assign gain_code   = r_gain;
  assign gain_update = r_gain_upd;
  assign spi_sclk    = r_sclk;
  assign spi_cs_n    = r_cs_n;
  assign spi_mosi    = r_mosi;
  assign spi_busy    = r_busy;

endmodule

// File: tb/tb_pga_gain_ctrl.sv
// Scoreboard bench for pga_gain_ctrl: stimulus pushes expected gain codes and SPI
// frames; independent monitors decode the DUT outputs and pop/compare.
module tb_pga_gain_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] S_TDATA;
  logic       S_TVALID;
  logic [3:0] gain_code;
  logic       gain_update;
  logic       spi_sclk, spi_cs_n, spi_mosi, spi_busy;

  int errors = 0;
  int checks = 0;
  int gain_m;
  int exp_gain[$];
  int exp_frame[$];
  bit collapse;
  int pend;

  pga_gain_ctrl #(
    .WINDOW_2N(2), .GAIN_W(4), .GAIN_MAX(15), .GAIN_INIT(8),
    .HI_THRESH(112), .LO_THRESH(40), .CLK_DIV(4), .CMD_BYTE(8'h40)
  ) dut (
    .clk(clk), .reset_n(reset_n), .S_TDATA(S_TDATA), .S_TVALID(S_TVALID),
    .gain_code(gain_code), .gain_update(gain_update), .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_busy(spi_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic int abs_sat(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return (m > 127) ? 127 : m;
  endfunction

  // Reference: a window's peak magnitude moves the gain one step with hysteresis.
  task automatic window(input int a, input int b, input int c, input int d);
    int s[4];
    int pk;
    int old;
    s = '{a, b, c, d};
    pk = 0;
    foreach (s[i]) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      S_TDATA  = 8'(s[i]);
      S_TVALID = 1'b1;
      @(posedge clk); #1;
      S_TVALID = 1'b0;
      if (abs_sat(s[i]) > pk) pk = abs_sat(s[i]);
    end
    old = gain_m;
    if (pk >= 112 && gain_m > 0) gain_m = gain_m - 1;
    else if (pk < 40 && gain_m < 15) gain_m = gain_m + 1;
    if (gain_m != old) begin
      exp_gain.push_back(gain_m);
      if (collapse) pend = 16'h4000 | gain_m;
      else exp_frame.push_back(16'h4000 | gain_m);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic model_reset();
    exp_gain.delete();
    exp_frame.delete();
    gain_m = 8;
    exp_frame.push_back(16'h4008);
  endtask

  // Gain monitor
  initial begin
    int prev_gain;
    int e;
    prev_gain = 8;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_gain = int'(gain_code);
      end else begin
        if (gain_update) begin
          if (exp_gain.size() == 0) check("gain_unexpected_pulse", 1, 0);
          else begin
            e = exp_gain.pop_front();
            check("gain_code_on_update", int'(gain_code), e);
          end
        end else if (int'(gain_code) != prev_gain) begin
          check("gain_change_without_pulse", 0, 1);
        end
        prev_gain = int'(gain_code);
      end
    end
  end

  // SPI frame monitor
  initial begin
    int cs_cnt, rises, busy_cnt, e;
    bit stable_ok, wait_busy;
    logic [15:0] cap;
    logic prev_sclk, prev_cs, prev_mosi;
    cs_cnt = 0; rises = 0; busy_cnt = 0; stable_ok = 1; wait_busy = 0; cap = '0;
    prev_sclk = 0; prev_cs = 1; prev_mosi = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cs_cnt = 0; rises = 0; stable_ok = 1; wait_busy = 0; cap = '0;
        prev_sclk = 0; prev_cs = 1; prev_mosi = 0;
      end else begin
        if (!spi_cs_n) begin
          cs_cnt++;
          if (spi_sclk && !prev_sclk) begin
            rises++;
            cap = {cap[14:0], spi_mosi};
            if (spi_mosi !== prev_mosi) stable_ok = 0;
          end
        end
        if (spi_cs_n && !prev_cs) begin
          check("frame_cs_low_cycles", cs_cnt, 128);
          check("frame_sclk_rises", rises, 16);
          check("frame_mosi_stable", int'(stable_ok), 1);
          if (exp_frame.size() == 0) check("frame_unexpected", int'(cap), 0);
          else begin
            e = exp_frame.pop_front();
            check("frame_data", int'(cap), e);
          end
          cs_cnt = 0; rises = 0; stable_ok = 1; cap = '0;
          wait_busy = 1; busy_cnt = 0;
        end
        if (wait_busy) begin
          if (spi_busy) busy_cnt++;
          else begin
            check("busy_after_cs_rise", busy_cnt, 4);
            wait_busy = 0;
          end
        end
        prev_sclk = spi_sclk; prev_cs = spi_cs_n; prev_mosi = spi_mosi;
      end
    end
  end

  initial begin
    int v[4];
    int cls;
    S_TDATA = '0; S_TVALID = 1'b0; collapse = 0; pend = 0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    model_reset();
    #20;
    check("rst_gain_code", int'(gain_code), 8);
    check("rst_gain_update", int'(gain_update), 0);
    check("rst_sclk", int'(spi_sclk), 0);
    check("rst_cs_n", int'(spi_cs_n), 1);
    check("rst_mosi", int'(spi_mosi), 0);
    check("rst_busy", int'(spi_busy), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    settle(180);

    window(10, -20, 30, -5);
    settle(180);
    window(0, 0, -128, 0);
    settle(180);
    repeat (9) begin
      window(0, 0, -128, 0);
      settle(180);
    end
    repeat (3) begin
      window(60, -60, 60, -60);
      settle(40);
    end
    repeat (16) begin
      window(1, -2, 3, 0);
      settle(180);
    end

    repeat (12) begin
      cls = $urandom_range(0, 2);
      foreach (v[i]) begin
        if (cls == 0) v[i] = $urandom_range(0, 39);
        else v[i] = $urandom_range(0, 127);
        if ($urandom_range(0, 1) == 1) v[i] = -v[i];
      end
      if (cls == 2) v[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 1) ? -128 : 115;
      window(v[0], v[1], v[2], v[3]);
      settle(180);
    end

    // Two decrements while the post-reset frame is still shifting
    @(posedge clk); #1 reset_n = 1'b0;
    model_reset();
    settle(2); #1 reset_n = 1'b1;
    settle(10);
    collapse = 1;
    window(0, 127, 0, 0);
    window(-128, 0, 0, 0);
    collapse = 0;
    exp_frame.push_back(pend);
    settle(300);
    check("gain_after_burst", int'(gain_code), 6);

    // Asynchronous reset in the middle of a frame
    window(5, 5, 5, 5);
    settle(40);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_cs_n", int'(spi_cs_n), 1);
    check("async_rst_sclk", int'(spi_sclk), 0);
    model_reset();
    #22 reset_n = 1'b1;
    settle(250);

    check("final_gain", int'(gain_code), gain_m);
    check("pending_gain_events", exp_gain.size(), 0);
    check("pending_frames", exp_frame.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pga_gain_ctrl.md
Name: pga_gain_ctrl

Overview:
Closed-loop analog gain controller for the hydrophone front end, working opposite to the digital AGC. It takes the raw ADC sample stream and measures peak magnitude over fixed windows. It then steps a programmable-gain-amplifier code up or down with hysteresis and writes that code to the external PGA over a write-only SPI master, so the ADC input stays in range before any digital normalisation.

Parameters:
WINDOW_2N, 8, window length is 2^WINDOW_2N valid samples
GAIN_W, 4, gain code width
GAIN_MAX, 15, highest legal gain code
GAIN_INIT, 8, gain code after reset
HI_THRESH, 112, window peak >= this steps gain down
LO_THRESH, 40, window peak < this steps gain up
CLK_DIV, 4, SCLK half-period in clk cycles (>=1)
CMD_BYTE, 8'h40, SPI command byte preceding the gain byte

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
S_TDATA  in  8  ADC sample, signed two's complement
S_TVALID  in  1  sample valid; no backpressure, every valid is consumed
gain_code  out  GAIN_W  current target gain
gain_update  out  1  one-cycle pulse when gain_code changes
spi_sclk  out  1  SPI clock, mode 0 (idle low)
spi_cs_n  out  1  PGA chip select, active low
spi_mosi  out  1  serial data, MSB first
spi_busy  out  1  high whenever the SPI FSM is not IDLE

Behaviour:
- Reset (asynchronous, reset_n low): gain_code=GAIN_INIT, gain_update=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0, spi_busy=0, peak=0, window count=0, sent_valid=0. Reset mid-transaction aborts it immediately: CS deasserts and the FSM returns to IDLE.
- Magnitude: mag = |S_TDATA|; -128 saturates to 127. Range is 0..127.
- Peak window:
  - Per valid sample: peak <= max(peak, mag); count increments.
  - On the valid sample where count = 2^WINDOW_2N-1, the decision uses pk = max(peak, mag), including that sample. Then peak<=0 and count<=0 in the same cycle.
- Decision, registered one cycle after the last window sample:
  - pk >= HI_THRESH and gain_code > 0: gain_code-1.
  - else pk < LO_THRESH and gain_code < GAIN_MAX: gain_code+1.
  - else unchanged. Gain is held at 0 and at GAIN_MAX, with no wrap.
  - gain_update pulses in the same cycle gain_code changes, and only if it changes.
- SPI FSM states: IDLE, SHIFT, CSHOLD.
  - Registers: sent_code, sent_valid.
  - IDLE: if !sent_valid or gain_code != sent_code, latch frame = {CMD_BYTE, zero-extended gain_code to 8 bits} (16 bits), latch gain_code as snap, and go to SHIFT. The first write of GAIN_INIT after reset is automatic.
  - SHIFT:
    - cs_n=0 from the first SHIFT cycle; mosi=frame[15] in that same cycle.
    - sclk rises after CLK_DIV cycles and falls CLK_DIV cycles later; mosi shifts to the next bit on each falling edge.
    - After the 16th falling edge: cs_n=1, mosi=0, go to CSHOLD.
    - CS is low for exactly 32*CLK_DIV cycles.
  - CSHOLD: hold cs_n high for CLK_DIV cycles, then sent_code<=snap, sent_valid<=1, go to IDLE.
  - A gain change during a transaction never corrupts the frame in flight. IDLE compares again and starts a new frame carrying the latest gain_code; intermediate codes may be skipped.
- spi_busy = (state != IDLE), registered with the state.
- No combinational path from S_TDATA to any output.

Test Plan:
- Reset release, no samples, CLK_DIV=4 → one frame 0x4008: CS low 128 cycles, 16 SCLK rising edges, MOSI stable on each rise; spi_busy low 4 cycles after CS rises.
- WINDOW_2N=2, 4 samples {10,-20,30,-5}, gain 8 → pk=30 < 40: gain_code=9, one gain_update pulse, frame 0x4009 follows.
- 4 samples {0,0,-128,0} → mag 127 ≥ 112: gain 8→7, frame 0x4007. Repeat with gain at 0 → stays 0, no pulse, no frame.
- Samples of 60 (between thresholds) for several windows → gain unchanged, no SPI activity. With gain at 15 and low samples → stays 15, no pulse.
- Two gain decrements (8→7→6) while the first frame is shifting → the in-flight frame completes unchanged; exactly one further frame 0x4006; final sent_code=6.
- reset_n asserted mid-SHIFT (asynchronous, not on a clock edge) → cs_n=1 and sclk=0 immediately; after release, frame 0x4008 is resent.
